// File: rtl/biasregc_rd_ctrl_pkg.sv
// Shared definitions for the bias register bank read sequencer.
`timescale 1ns/1ps
package biasregc_rd_ctrl_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_e;

    // Read return latency of the bias register bank, in cycles
    localparam int BR_RD_LAT = 4;

    // Default geometry shared with biasregc
    localparam int BR_ADDR_WTH_DEF = 9;
    localparam int BR_IND_WTH_DEF  = 1;
    localparam int CREDITS_DEF     = 8;

    // Cycles after reset release during which returns with nothing in flight
    // are treated as leftovers of an aborted command and silently dropped
    localparam int BLANK_CYCLES = 2 * BR_RD_LAT;

endpackage

// File: rtl/biasregc_crd_cnt.sv
// Up/down saturating counter with range-violation flags.
// inc and dec in the same cycle cancel; a flag is raised only when the net
// change would leave the range [0, MAX], and the count then holds.
`timescale 1ns/1ps
module biasregc_crd_cnt #(
    parameter int WTH  = 4,
    parameter int INIT = 0,
    parameter int MAX  = 8
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    input  logic           inc_i,
    input  logic           dec_i,
    output logic [WTH-1:0] cnt_o,
    output logic           ovf_o,
    output logic           unf_o
);
    localparam logic [WTH-1:0] INIT_V = WTH'(INIT);
    localparam logic [WTH-1:0] MAX_V  = WTH'(MAX);

    logic [WTH-1:0] cnt_q;

    assign cnt_o = cnt_q;

    // Flag an increment at the ceiling or a decrement at the floor
    always_comb begin
        // NOTE: every output of a combinational block is assigned on every path, otherwise a latch is inferred.
        ovf_o = inc_i && !dec_i && (cnt_q == MAX_V);
        unf_o = dec_i && !inc_i && (cnt_q == '0);
    end

    // Apply the net change unless it would leave the legal range
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= INIT_V;
        end else if (inc_i && !dec_i && !ovf_o) begin
            // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
            cnt_q <= cnt_q + 1'b1;
        end else if (dec_i && !inc_i && !unf_o) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

endmodule

// File: rtl/biasregc_rd_ctrl.sv
// Read sequencer for the bias register bank on the vputy path: walks
// base..base+len for rpt+1 passes, paced by downstream credits, and signals
// done once every issued read has returned.
`timescale 1ns/1ps
module biasregc_rd_ctrl
    import biasregc_rd_ctrl_pkg::*;
#(
    parameter int BR_IND_WTH  = BR_IND_WTH_DEF,
    parameter int BR_ADDR_WTH = BR_ADDR_WTH_DEF,
    parameter int LEN_WTH     = 9,
    parameter int RPT_WTH     = 8,
    parameter int CREDITS     = CREDITS_DEF,
    parameter int CRD_WTH     = 4,
    parameter int OUT_WTH     = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic [BR_IND_WTH-1:0]  cmd_index_i,
    input  logic [BR_ADDR_WTH-1:0] cmd_base_addr_i,
    input  logic [LEN_WTH-1:0]     cmd_len_i,
    input  logic [RPT_WTH-1:0]     cmd_rpt_i,
    output logic                   vputy_brc__re_o,
    output logic [BR_ADDR_WTH-1:0] vputy_brc__raddr_o,
    output logic [BR_IND_WTH-1:0]  vputy_brc__rindex_o,
    input  logic                   vputy_brc__rdata_act_i,
    input  logic                   dn_credit_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_o
);
    localparam int BLK_WTH = $clog2(BLANK_CYCLES + 1);

    rd_state_e              state_q;
    logic [BR_ADDR_WTH-1:0] base_q;
    logic [BR_ADDR_WTH-1:0] addr_q;
    logic [BR_ADDR_WTH-1:0] raddr_q;
    logic [BR_IND_WTH-1:0]  rindex_q;
    logic [LEN_WTH-1:0]     len_q;
    logic [LEN_WTH-1:0]     len_cnt_q;
    logic [RPT_WTH-1:0]     rpt_q;
    logic [RPT_WTH-1:0]     pass_cnt_q;
    logic                   re_q;
    logic                   done_q;
    logic                   err_q;
    logic [BLK_WTH-1:0]     blank_q;

    logic [CRD_WTH-1:0]     credit;
    logic [OUT_WTH-1:0]     outstanding;
    logic                   crd_ovf;
    logic                   crd_unf;
    logic                   out_ovf;
    logic                   out_unf;

    logic                   issue;
    logic                   blank;
    logic                   act_take;

    // A read goes out on every ISSUE cycle that holds at least one credit
    assign issue = (state_q == ST_ISSUE) && (credit != '0);

    // Right after reset, a return with nothing in flight belongs to the
    // aborted command: drop it rather than count it as an underflow
    assign blank    = (blank_q != '0);
    assign act_take = vputy_brc__rdata_act_i && !(blank && (outstanding == '0));

    assign cmd_ready_o         = (state_q == ST_IDLE);
    assign busy_o              = (state_q != ST_IDLE);
    assign vputy_brc__re_o     = re_q;
    assign vputy_brc__raddr_o  = raddr_q;
    assign vputy_brc__rindex_o = rindex_q;
    assign done_o              = done_q;
    assign err_o               = err_q;

    // Downstream buffer entries still free
    biasregc_crd_cnt #(
        .WTH  (CRD_WTH),
        .INIT (CREDITS),
        .MAX  (CREDITS)
    ) u_credit (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .inc_i   (dn_credit_i),
        .dec_i   (issue),
        .cnt_o   (credit),
        .ovf_o   (crd_ovf),
        .unf_o   (crd_unf)
    );

    // Reads issued whose data has not yet returned
    biasregc_crd_cnt #(
        .WTH  (OUT_WTH),
        .INIT (0),
        .MAX  (CREDITS)
    ) u_outstanding (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .inc_i   (issue),
        .dec_i   (act_take),
        .cnt_o   (outstanding),
        .ovf_o   (out_ovf),
        .unf_o   (out_unf)
    );

    // Count down the post-reset window for stale read returns
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            blank_q <= BLK_WTH'(BLANK_CYCLES);
        end else if (blank_q != '0) begin
            blank_q <= blank_q - 1'b1;
        end
    end

    // Command sequencer with registered read strobe, done pulse and error
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            // NOTE: every register here is small control state and takes the async reset; no storage array is involved.
            state_q    <= ST_IDLE;
            base_q     <= '0;
            addr_q     <= '0;
            raddr_q    <= '0;
            rindex_q   <= '0;
            len_q      <= '0;
            len_cnt_q  <= '0;
            rpt_q      <= '0;
            pass_cnt_q <= '0;
            re_q       <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            re_q   <= 1'b0;
            done_q <= 1'b0;
            // Saturation of either counter is a protocol error; the two
            // flags that cannot fire in normal operation are kept as a net
            err_q  <= err_q | crd_ovf | crd_unf | out_ovf | out_unf;

            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid_i) begin
                        base_q     <= cmd_base_addr_i;
                        addr_q     <= cmd_base_addr_i;
                        rindex_q   <= cmd_index_i;
                        len_q      <= cmd_len_i;
                        rpt_q      <= cmd_rpt_i;
                        len_cnt_q  <= '0;
                        pass_cnt_q <= '0;
                        state_q    <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    if (issue) begin
                        re_q    <= 1'b1;
                        raddr_q <= addr_q;
                        if (len_cnt_q == len_q) begin
                            if (pass_cnt_q == rpt_q) begin
                                state_q <= ST_DRAIN;
                            end else begin
                                pass_cnt_q <= pass_cnt_q + 1'b1;
                                len_cnt_q  <= '0;
                                addr_q     <= base_q;
                            end
                        end else begin
                            len_cnt_q <= len_cnt_q + 1'b1;
                            addr_q    <= addr_q + 1'b1;
                        end
                    end
                end

                ST_DRAIN: begin
                    if ((outstanding == '0) && !vputy_brc__rdata_act_i) begin
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_biasregc_rd_ctrl.sv
// Self-checking bench for biasregc_rd_ctrl: a bias-bank return model, a
// credit loopback, a vector table, random commands and corner sequences.
`timescale 1ns/1ps
module tb_biasregc_rd_ctrl;

    localparam int AW = 9;
    localparam int IW = 1;
    localparam int LW = 9;
    localparam int RW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [IW-1:0] cmd_index;
    logic [AW-1:0] cmd_base;
    logic [LW-1:0] cmd_len;
    logic [RW-1:0] cmd_rpt;
    logic          re;
    logic [AW-1:0] raddr;
    logic [IW-1:0] rindex;
    logic          rdata_act = 1'b0;
    logic          dn_credit = 1'b0;
    logic          busy;
    logic          done;
    logic          err;

    always #5 clk = ~clk;

    biasregc_rd_ctrl dut (
        .clk_i                  (clk),
        .rst_n_i                (rst_n),
        .cmd_valid_i            (cmd_valid),
        .cmd_ready_o            (cmd_ready),
        .cmd_index_i            (cmd_index),
        .cmd_base_addr_i        (cmd_base),
        .cmd_len_i              (cmd_len),
        .cmd_rpt_i              (cmd_rpt),
        .vputy_brc__re_o        (re),
        .vputy_brc__raddr_o     (raddr),
        .vputy_brc__rindex_o    (rindex),
        .vputy_brc__rdata_act_i (rdata_act),
        .dn_credit_i            (dn_credit),
        .busy_o                 (busy),
        .done_o                 (done),
        .err_o                  (err)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, actual, required);
        end
    endtask

    // ---------------------------------------------------------------------
    // Environment: bank returns act 4 cycles after each read, downstream
    // returns a credit 4 cycles after each act (when looped), plus manual
    // credits and injected spurious acts. Everything observed is logged.
    // ---------------------------------------------------------------------
    logic [4:0]    re_hist  = '0;
    logic [4:0]    act_hist = '0;
    logic          br_en    = 1'b1;
    logic          loop_en  = 1'b1;
    logic          spur_act = 1'b0;
    int            man_req  = 0;
    int            man_done = 0;
    int            samp     = 0;
    int            last_act_samp = -100;
    int            idx_bad  = 0;
    logic [IW-1:0] exp_idx  = '0;
    logic [AW-1:0] rd_log[$];
    int            rd_samp[$];
    int            done_samp[$];

    always @(posedge clk) begin
        logic br_act;
        logic crd;
        #1;
        samp++;
        re_hist  = {re_hist[3:0], re};
        br_act   = br_en && re_hist[4];
        act_hist = {act_hist[3:0], br_act};
        crd      = loop_en && act_hist[4];
        if ((man_req != man_done) && !crd) begin
            crd = 1'b1;
            man_done++;
        end
        rdata_act = br_act | spur_act;
        dn_credit = crd;
        if (br_act) last_act_samp = samp;
        if (re) begin
            rd_log.push_back(raddr);
            rd_samp.push_back(samp);
            if (rindex !== exp_idx) idx_bad++;
        end
        if (done) done_samp.push_back(samp);
    end

    // ---------------------------------------------------------------------
    // Command helpers and reference model
    // ---------------------------------------------------------------------
    int cur_rd0;
    int cur_dn0;
    int cur_acc;

    task automatic start_cmd(input logic [IW-1:0] idx, input logic [AW-1:0] base,
                             input logic [LW-1:0] len, input logic [RW-1:0] rpt);
        cur_rd0 = rd_log.size();
        cur_dn0 = done_samp.size();
        exp_idx = idx;
        @(negedge clk);
        check("cmd_ready_idle", int'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_index = idx;
        cmd_base  = base;
        cmd_len   = len;
        cmd_rpt   = rpt;
        @(negedge clk);
        cmd_valid = 1'b0;
        cur_acc   = samp;
        @(negedge clk);
        check("first_read_latency",
              (rd_log.size() > cur_rd0) ? rd_samp[cur_rd0] - cur_acc : -1, 1);
    endtask

    // The last act is taken at the edge after it is driven; done registers one edge later
    task automatic wait_done(input int budget);
        int t = 0;
        while ((done_samp.size() == cur_dn0) && (t < budget)) begin
            @(negedge clk);
            t++;
        end
        check("done_vs_last_act",
              (done_samp.size() > cur_dn0) ? done_samp[cur_dn0] - last_act_samp : -1, 2);
        repeat (8) @(negedge clk);
        check("done_count", done_samp.size() - cur_dn0, 1);
        check("rindex_mismatches", idx_bad, 0);
        check("err_clear", int'(err), 0);
        check("busy_after_done", int'(busy), 0);
    endtask

    // Expected stream: rpt+1 passes over base..base+len, modulo the address space
    task automatic verify_reads(input int rd0, input int rd_end, input logic [AW-1:0] base,
                                input logic [LW-1:0] len, input logic [RW-1:0] rpt,
                                input int exp_n);
        int n   = 0;
        int bad = 0;
        logic [AW-1:0] a;
        for (int p = 0; p <= int'(rpt); p++) begin
            for (int l = 0; l <= int'(len); l++) begin
                a = AW'(int'(base) + l);
                if ((rd0 + n >= rd_end) || (rd_log[rd0 + n] !== a)) bad++;
                n++;
            end
        end
        check("read_count", rd_end - rd0, exp_n);
        check("read_addr_mismatches", bad, 0);
    endtask

    task automatic run_cmd(input logic [IW-1:0] idx, input logic [AW-1:0] base,
                           input logic [LW-1:0] len, input logic [RW-1:0] rpt,
                           input int exp_n);
        start_cmd(idx, base, len, rpt);
        wait_done(600);
        verify_reads(cur_rd0, rd_log.size(), base, len, rpt, exp_n);
    endtask

    typedef struct {
        logic [IW-1:0] idx;
        logic [AW-1:0] base;
        logic [LW-1:0] len;
        logic [RW-1:0] rpt;
        int            exp_reads;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at sample %0d", samp);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int rd0;
        int dn0;
        int done_s;
        int n1;
        int rst_samp;

        vecs[0] = '{1'b0, 9'h010, 9'd3, 8'd0, 4};   // basic
        vecs[1] = '{1'b1, 9'h1FE, 9'd2, 8'd1, 6};   // repeat with wrap
        vecs[2] = '{1'b0, 9'h000, 9'd0, 8'd0, 1};   // single read
        vecs[3] = '{1'b1, 9'h1FF, 9'd0, 8'd2, 3};   // one address, three passes
        vecs[4] = '{1'b0, 9'h100, 9'd8, 8'd0, 9};   // longer than the credit pool

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_index = '0;
        cmd_base  = '0;
        cmd_len   = '0;
        cmd_rpt   = '0;
        #12;
        check("rst_re", int'(re), 0);
        check("rst_raddr", int'(raddr), 0);
        check("rst_rindex", int'(rindex), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_ready", int'(cmd_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // Vector table
        for (int i = 0; i < 5; i++) begin
            run_cmd(vecs[i].idx, vecs[i].base, vecs[i].len, vecs[i].rpt, vecs[i].exp_reads);
        end
        // Basic command reads land on consecutive cycles
        check("basic_consecutive",
              (rd_samp.size() >= 4) ? rd_samp[3] - rd_samp[0] : -1, 3);

        // Randomized commands against the model
        for (int i = 0; i < 10; i++) begin
            logic [IW-1:0] ri;
            logic [AW-1:0] rb;
            logic [LW-1:0] rl;
            logic [RW-1:0] rr;
            ri = IW'($urandom_range(0, 1));
            rb = AW'($urandom_range(0, 511));
            rl = LW'($urandom_range(0, 15));
            rr = RW'($urandom_range(0, 3));
            run_cmd(ri, rb, rl, rr, (int'(rl) + 1) * (int'(rr) + 1));
        end

        // Credit stall: no loopback, 12 reads against 8 credits
        repeat (12) @(negedge clk);
        loop_en = 1'b0;
        start_cmd(1'b0, 9'h120, 9'd11, 8'd0);
        repeat (20) @(negedge clk);
        check("stall_reads", rd_log.size() - cur_rd0, 8);
        check("stall_re_low", int'(re), 0);
        check("stall_busy", int'(busy), 1);
        man_req += 4;
        wait_done(100);
        verify_reads(cur_rd0, rd_log.size(), 9'h120, 9'd11, 8'd0, 12);
        man_req += 8;
        repeat (12) @(negedge clk);

        // Credit returned while issuing adds exactly one read before the stall
        start_cmd(1'b1, 9'h1F0, 9'd9, 8'd0);
        man_req += 1;
        repeat (20) @(negedge clk);
        check("simul_credit_reads", rd_log.size() - cur_rd0, 9);
        man_req += 1;
        wait_done(100);
        verify_reads(cur_rd0, rd_log.size(), 9'h1F0, 9'd9, 8'd0, 10);
        man_req += 8;
        repeat (12) @(negedge clk);
        loop_en = 1'b1;

        // Back-to-back: second command waiting with valid held high
        rd0 = rd_log.size();
        dn0 = done_samp.size();
        exp_idx = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_index = 1'b0;
        cmd_base  = 9'h0C0;
        cmd_len   = 9'd3;
        cmd_rpt   = 8'd0;
        @(negedge clk);
        cmd_index = 1'b1;
        cmd_base  = 9'h0E0;
        cmd_len   = 9'd1;
        cmd_rpt   = 8'd1;
        t = 0;
        while ((done_samp.size() == dn0) && (t < 100)) begin
            @(negedge clk);
            t++;
        end
        check("b2b_ready_with_done", int'(cmd_ready), 1);
        exp_idx = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("b2b_busy_after_accept", int'(busy), 1);
        cur_dn0 = dn0 + 1;
        wait_done(100);
        done_s = (done_samp.size() > dn0) ? done_samp[dn0] : 0;
        n1 = 0;
        for (int k = rd0; k < rd_log.size(); k++) begin
            if (rd_samp[k] < done_s) n1++;
        end
        verify_reads(rd0, rd0 + n1, 9'h0C0, 9'd3, 8'd0, 4);
        check("b2b_first_read_gap",
              (rd_samp.size() > rd0 + n1) ? rd_samp[rd0 + n1] - done_s : -1, 2);
        verify_reads(rd0 + n1, rd_log.size(), 9'h0E0, 9'd1, 8'd1, 4);

        // Spurious act in IDLE, well past the post-reset window
        repeat (12) @(negedge clk);
        spur_act = 1'b1;
        @(negedge clk);
        spur_act = 1'b0;
        @(negedge clk);
        check("spurious_act_err", int'(err), 1);
        repeat (5) @(negedge clk);
        check("err_sticky", int'(err), 1);

        // Reset after the third read of an 8-read command
        loop_en = 1'b0;
        start_cmd(1'b1, 9'h040, 9'd7, 8'd0);
        t = 0;
        while ((rd_log.size() < cur_rd0 + 3) && (t < 20)) begin
            @(negedge clk);
            t++;
        end
        rst_n = 1'b0;
        rst_samp = samp;
        #1;
        check("midrst_re", int'(re), 0);
        check("midrst_raddr", int'(raddr), 0);
        check("midrst_rindex", int'(rindex), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_ready", int'(cmd_ready), 1);
        check("midrst_err", int'(err), 0);
        check("midrst_done", int'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("midrst_reads_stopped", rd_log.size() - cur_rd0, 3);
        check("midrst_stale_acts_seen", int'(last_act_samp > rst_samp), 1);
        check("midrst_stale_acts_no_err", int'(err), 0);
        loop_en = 1'b1;
        run_cmd(1'b0, 9'h0AB, 9'd5, 8'd1, 12);

        // Credit returned into a full pool is an error
        repeat (12) @(negedge clk);
        man_req += 1;
        repeat (4) @(negedge clk);
        check("credit_overflow_err", int'(err), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/biasregc_rd_ctrl.md
Name: biasregc_rd_ctrl

Overview:
- Read sequencer for the bias register bank (BR) on the vputy path.
- Accepts one command at a time. A command carries base address, length, repeat count and bank index.
- Emits the BR read strobe/address stream toward biasregc.
- Paces issue with a downstream credit pool, tracks reads in flight against the returned rdata_act, and reports completion once every issued read has returned.

Parameters:
- BR_IND_WTH, 1, bank index width
- BR_ADDR_WTH, 9, BR address width
- LEN_WTH, 9, command length field width (length-1 encoding)
- RPT_WTH, 8, repeat field width (repeats-1 encoding)
- CREDITS, 8, downstream buffer entries; initial credit count
- CRD_WTH, 4, credit counter width, must hold CREDITS
- OUT_WTH, 4, in-flight counter width, must hold CREDITS

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command accepted when valid&ready
- cmd_index_i  in  BR_IND_WTH  bank index
- cmd_base_addr_i  in  BR_ADDR_WTH  first address
- cmd_len_i  in  LEN_WTH  addresses per pass minus 1
- cmd_rpt_i  in  RPT_WTH  passes minus 1
- vputy_brc__re_o  out  1  BR read enable, registered
- vputy_brc__raddr_o  out  BR_ADDR_WTH  BR read address, registered
- vputy_brc__rindex_o  out  BR_IND_WTH  BR bank index, registered
- vputy_brc__rdata_act_i  in  1  read data valid returned by BR
- dn_credit_i  in  1  downstream freed one entry
- busy_o  out  1  state != IDLE
- done_o  out  1  one-cycle pulse at command completion
- err_o  out  1  sticky protocol error

Behaviour:
- Reset values (async, rst_n_i low):
  - state=IDLE
  - re_o=0, raddr_o=0, rindex_o=0, done_o=0, err_o=0, busy_o=0
  - credit=CREDITS, outstanding=0
  - cmd_ready_o=1
- A reset mid-command aborts the command. Reads already issued are not tracked afterwards; their late rdata_act is ignored for 8 cycles after reset release (blanking counter), so it does not raise err_o.
- FSM states:
  - IDLE: cmd_ready_o=1. On valid&ready, latch all command fields; addr=base, pass_cnt=0, len_cnt=0; go to ISSUE.
  - ISSUE: each cycle with credit>0, drive re_o=1 and raddr_o=addr on the next edge.
    - Decrement credit.
    - Increment outstanding.
    - Advance addr=addr+1, modulo 2^BR_ADDR_WTH. Wrap is legal.
    - When len_cnt==len: if pass_cnt==rpt, go to DRAIN; else pass_cnt++, len_cnt=0, addr=base.
    - credit==0: re_o=0 and the state holds (stall).
  - DRAIN: re_o=0. When outstanding==0 (and no act arriving this cycle), pulse done_o, go to IDLE.
- Command-to-first-read latency: command accepted on edge N, first re_o high after edge N+1, provided credit>0.
- rdata_act returns 4 cycles after re; outstanding is decremented on each act.
- Simultaneous events:
  - Issue and dn_credit_i in the same cycle: credit unchanged.
  - Issue and act in the same cycle: outstanding unchanged.
- Errors (set err_o, sticky until reset):
  - dn_credit_i while credit==CREDITS (credit saturates).
  - act while outstanding==0 outside the blanking window (counter holds at 0).
- Total reads per command = (len+1)*(rpt+1). Arithmetic is unsigned; counters wrap only where stated.
- done_o and cmd accept can be back-to-back: done at edge M, cmd_ready_o=1 in the cycle after M.
- rindex_o holds the latched index for the whole command and keeps its value in IDLE.

Decomposition:
- Shared package: FSM state encoding (IDLE/ISSUE/DRAIN), BR_RD_LAT=4, and the default widths of BR_ADDR_WTH, BR_IND_WTH and CREDITS shared with biasregc.
- Natural sub-module: biasregc_crd_cnt, a generic up/down saturating counter with overflow/underflow flags. Instantiate it twice: once for credit, once for outstanding.

Test Plan:
- Basic command: base=0x010, len=3, rpt=0, dn_credit looped back 4 cycles after act → raddr 0x010..0x013 on 4 consecutive cycles, done_o one cycle after the last act, err_o=0.
- Repeat with address wrap: base=0x1FE, len=2, rpt=1 → addresses 1FE,1FF,000,1FE,1FF,000; 6 acts; one done_o.
- Credit stall: CREDITS=8, no dn_credit_i, len=11 → exactly 8 reads, then re_o=0. Release 4 credits → 4 more reads, then DRAIN, then done.
- Simultaneous events: issue and dn_credit_i in the same cycle → credit unchanged. Spurious act in IDLE after the blanking window → err_o=1 and stays 1.
- Reset mid-command: assert rst_n_i after the 3rd read of len=7 → all outputs at reset values asynchronously. After release, the in-flight acts produce no err_o; a new command runs normally.
- Back-to-back commands: second cmd_valid_i held high during the first → accepted the cycle after done_o; its first read follows 1 cycle later.
